// File: rtl/accumulator_bus_requester.sv
// accumulator_bus_requester: arbitrated single-command bus requester (optional XFER timeout via BUS_REQ_TIMEOUT_EN)
module accumulator_bus_requester #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        req,
    input  logic        grant,
    output wire  [1:0]  op,
    input  logic        signal,
    input  logic [31:0] read,
    output wire  [31:0] write,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_WR = 2'b10;
    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [31:0] data_q;
    logic        err_nx;
    logic        cap_rd;
    logic        op_ok;
    assign op_ok     = (cmd_op == OP_RD) || (cmd_op == OP_WR);
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign req       = (state == REQ) || (state == XFER);
    assign rsp_valid = state == DONE;
    assign op        = (state == XFER) ? op_q : 2'bz;
    assign write     = (state == XFER && op_q == OP_WR) ? data_q : 32'bz;
`ifdef BUS_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          tmo;
    assign tmo = cnt == CW'(TIMEOUT - 1);
    // Counts XFER cycles spent waiting; restarts every time XFER is (re)entered
    always_ff @(posedge clk) begin
        if (!reset || state != XFER)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
`else
    localparam int unused_timeout = TIMEOUT;
    logic tmo;
    assign tmo = 1'b0;
`endif
    // Next state; signal beats grant loss, grant loss retries, timeout aborts
    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        cap_rd   = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                state_nx = op_ok ? REQ : DONE;
                err_nx   = !op_ok;
            end
            REQ:  if (grant) state_nx = XFER;
            XFER: if (signal) begin
                state_nx = DONE;
                cap_rd   = op_q == OP_RD;
            end else if (!grant) begin
                state_nx = REQ;
            end else if (tmo) begin
                state_nx = DONE;
                err_nx   = 1'b1;
            end
            DONE: state_nx = IDLE;
        endcase
    end
    // State, latched command and response registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= 2'b00;
            data_q   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (cmd_valid && cmd_ready) {op_q, data_q} <= {cmd_op, cmd_data};
            if (cap_rd) rsp_data <= read;
            if (state_nx == DONE) rsp_err <= err_nx;
        end
    end
endmodule
